// File: rtl/arith_pkg.sv
// Shared constants and FSM state type for the sequential 32-bit signed divider.
package arith_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LZ_W   = 5;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/seq_divider_32_if.sv
// Request/result bundle for seq_divider_32.
//   start, dividend, divisor       : request side (driven by master)
//   busy, done, quotient, remainder,
//   div_by_zero, dividend_lz       : status/result side (driven by slave)
interface seq_divider_32_if;
  import arith_pkg::*;

  logic              start;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;
  logic [LZ_W-1:0]   dividend_lz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dividend_lz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dividend_lz
  );

endinterface

// File: rtl/lzc32.sv
// Combinational leading-zero counter.
//   value    : 32-bit input
//   count    : number of leading zeros, saturated at 31
//   all_zero : value == 0
module lzc32
  import arith_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic [LZ_W-1:0]   count,
  output logic              all_zero
);

  logic [5:0] cnt;
  logic       found;

  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (value[i]) found = 1'b1;
        else          cnt   = cnt + 6'd1;
      end
    end
  end

  // An all-zero input would count 32; report 31 so the result fits LZ_W bits.
  assign count    = cnt[5] ? 5'd31 : cnt[4:0];
  assign all_zero = (value == '0);

endmodule

// File: rtl/seq_divider_32.sv
// Sequential signed 32-bit divider, one restoring quotient bit per cycle.
// Iteration starts at the dividend's leading one, so latency is N+2 cycles
// with N = 32 - lz (N = 0 when either operand is zero).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request (start/dividend/divisor) and result/status signals
module seq_divider_32
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  seq_divider_32_if.slave  bus
);

  state_e            state_q, state_d;
  logic              start_d_q;
  logic              accept;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic              sign_a_q, sign_b_q;
  logic [DATA_W-1:0] abs_b_q, shift_a_q, quo_acc_q, rem_acc_q;
  logic [LZ_W-1:0]   lz_q;
  logic [5:0]        cnt_q;
  logic [DATA_W-1:0] quot_q, rem_q;
  logic              dbz_q;
  logic [LZ_W-1:0]   lz_out_q;

  logic [DATA_W-1:0] abs_a, abs_b, rem_next;
  logic [LZ_W-1:0]   lz_c;
  logic              a_zero, bypass, ge;
  logic [DATA_W:0]   trial;

  // Magnitude as unsigned: INT_MIN maps onto itself, which is the correct 2^31.
  assign abs_a  = op_a_q[DATA_W-1] ? ('0 - op_a_q) : op_a_q;
  assign abs_b  = op_b_q[DATA_W-1] ? ('0 - op_b_q) : op_b_q;
  assign bypass = a_zero || (op_b_q == '0);

  lzc32 u_lzc (
    .value    (abs_a),
    .count    (lz_c),
    .all_zero (a_zero)
  );

  // Restoring step: bring down the next dividend bit, subtract if it fits.
  assign trial    = {rem_acc_q, shift_a_q[DATA_W-1]};
  assign ge       = trial >= {1'b0, abs_b_q};
  assign rem_next = ge ? (trial[DATA_W-1:0] - abs_b_q) : trial[DATA_W-1:0];

  assign accept = bus.start && !start_d_q && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (accept) state_d = StPrep;
      StPrep:         state_d = bypass ? StFix : StIter;
      StIter:         if (cnt_q == 6'd1) state_d = StFix;
      StFix:          state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      abs_b_q   <= '0;
      shift_a_q <= '0;
      quo_acc_q <= '0;
      rem_acc_q <= '0;
      lz_q      <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      lz_out_q  <= '0;
    end else begin
      start_d_q <= bus.start;
      if (accept) begin
        op_a_q <= bus.dividend;
        op_b_q <= bus.divisor;
      end
      unique case (state_q)
        StPrep: begin
          sign_a_q  <= op_a_q[DATA_W-1];
          sign_b_q  <= op_b_q[DATA_W-1];
          abs_b_q   <= abs_b;
          // Align the leading one to the MSB so iteration starts at bit 31-lz.
          shift_a_q <= abs_a << lz_c;
          lz_q      <= lz_c;
          quo_acc_q <= '0;
          rem_acc_q <= '0;
          cnt_q     <= bypass ? 6'd0 : (6'd32 - {1'b0, lz_c});
        end
        StIter: begin
          rem_acc_q <= rem_next;
          quo_acc_q <= {quo_acc_q[DATA_W-2:0], ge};
          shift_a_q <= {shift_a_q[DATA_W-2:0], 1'b0};
          cnt_q     <= cnt_q - 6'd1;
        end
        StFix: begin
          lz_out_q <= lz_q;
          if (op_b_q == '0) begin
            quot_q <= DIV0_QUOT;
            rem_q  <= op_a_q;
            dbz_q  <= 1'b1;
          end else begin
            // INT_MIN / -1 yields magnitude 2^31 with a positive sign -> INT_MIN.
            quot_q <= (sign_a_q ^ sign_b_q) ? ('0 - quo_acc_q) : quo_acc_q;
            rem_q  <= sign_a_q ? ('0 - rem_acc_q) : rem_acc_q;
            dbz_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
  assign bus.done        = (state_q == StDone);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.dividend_lz = lz_out_q;

endmodule

// File: doc/seq_divider_32.md
SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
REQ-003 SHALL have port: start  input  1  request; a request is accepted on a rising edge (start=1, registered start_d=0) seen in IDLE or DONE.
REQ-004 SHALL have port: dividend  input  32  signed two's-complement, sampled on the accepting edge.
REQ-005 SHALL have port: divisor  input  32  signed two's-complement, sampled on the accepting edge.
REQ-006 SHALL have port: busy  output  1  high in PREP, ITER and FIX.
REQ-007 SHALL have port: done  output  1  high in DONE, held until the next accepted request.
REQ-008 SHALL have port: quotient  output  32  signed result, valid while done=1.
REQ-009 SHALL have port: remainder  output  32  signed result, valid while done=1.
REQ-010 SHALL have port: div_by_zero  output  1  flag, valid while done=1.
REQ-011 SHALL have port: dividend_lz  output  5  leading-zero count of |dividend|, saturated at 31, valid while done=1.

Function
REQ-012 SHALL implement states IDLE, PREP, ITER, FIX and DONE.
REQ-013 SHALL take the transitions IDLE/DONE->PREP on an accepted request; PREP->ITER; PREP->FIX if divisor=0 or dividend=0; ITER->FIX after N iterations; FIX->DONE.
REQ-014 PREP SHALL register the sign of each operand, |dividend| and |divisor| as 32-bit unsigned values (|0x80000000| = 0x80000000), and lz = LZC(|dividend|).
REQ-015 ITER SHALL perform one restoring quotient bit per cycle, starting at bit 31-lz, for N = 32-lz iterations; N = 0 on the bypass path.
REQ-016 Latency SHALL be fixed: done rises N+2 cycles after the accepting edge.
REQ-017 Rounding SHALL truncate toward zero.
REQ-018 The quotient sign SHALL be sign(dividend) XOR sign(divisor), and the remainder sign SHALL follow the dividend.
REQ-019 Divisor = 0 SHALL give quotient=0xFFFFFFFF, remainder=dividend and div_by_zero=1.
REQ-020 0x80000000 / -1 SHALL give quotient=0x80000000 and remainder=0, with no flag.
REQ-021 Dividend = 0 with a nonzero divisor SHALL give quotient=0 and remainder=0; dividend_lz SHALL report 31.
REQ-022 A start rising edge while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023 Start held high continuously SHALL produce exactly one request.
REQ-024 Outputs SHALL update only in FIX and SHALL remain stable in DONE.
REQ-025 A new request accepted in DONE SHALL clear done on that edge.

Reset
REQ-026 On rst_n=0 the state SHALL go to IDLE immediately, asynchronously.
REQ-027 On rst_n=0 busy, done, quotient, remainder, div_by_zero, dividend_lz and start_d SHALL all be 0.
REQ-028 A reset mid-operation SHALL abandon that operation with no later done for it.
REQ-029 The first request SHALL be accepted on the first start rising edge after rst_n deasserts.

Structure
REQ-030 The shared package arith_pkg SHALL hold the state enumeration, DATA_W=32, LZ_W=5 and the constants DIV0_QUOT=0xFFFFFFFF and INT_MIN=0x80000000.
REQ-031 Sub-module lzc32 SHALL be purely combinational: 32-bit input, 5-bit saturated count output and an all_zero flag.
REQ-032 Iteration control SHALL use a 6-bit down-counter loaded with N.

Verification
REQ-033 Scenario 100 / 7 SHALL give quotient=14, remainder=2, dividend_lz=25, done at 9 cycles.
REQ-034 Scenario -100 / 7 SHALL give quotient=-14 and remainder=-2; 100 / -7 SHALL give quotient=-14 and remainder=2; -100 / -7 SHALL give quotient=14 and remainder=-2.
REQ-035 Scenario 7 / 0 SHALL give quotient=0xFFFFFFFF, remainder=7, div_by_zero=1, done at 2 cycles.
REQ-036 Scenario 0x80000000 / -1 SHALL give quotient=0x80000000, remainder=0, dividend_lz=0, done at 34 cycles.
REQ-037 Scenario: second start pulse 3 cycles into 100 / 7, then 50 / 5 requested after done, SHALL give the first result unchanged at 9 cycles, then quotient=10 and remainder=0.
REQ-038 Scenario: rst_n=0 for 1 cycle in mid-ITER of 0x7FFFFFFF / 3 SHALL clear all outputs, produce no done, and a following 12 / 10 SHALL give quotient=1 and remainder=2.
